// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage : RV32I instruction decode stage between IF and EX.
//
// Decodes one instruction per cycle into the control bundle and holds the
// result in a two-entry buffer (OUT drives the id_* ports, SKID catches one
// extra instruction while EX stalls), so if_ready comes straight from a flop.
//
// Optional feature: define RV32M_EN to decode the M extension (OP opcode with
// funct7 = 0000001). Without it those encodings are illegal and
// id_muldiv / id_muldiv_op stay 0.
//
// Encodings:
//   id_alu_opcode    one-hot  [0]ADD [1]SUB [2]SLL [3]SLT [4]SLTU
//                             [5]XOR [6]SRL [7]SRA [8]OR  [9]AND
//   id_branch_opcode          [0]EQ  [1]LT  [2]NEGATE
//   id_mem_opcode    one-hot  [0]byte [1]half [2]word
//
// Ports:
//   clk, rst_b          clock, synchronous active-low reset
//   flush               drop both held entries and any input this cycle
//   if_valid/if_ready   IF handshake (if_ready registered)
//   if_instr, if_pc     instruction word and its PC
//   id_valid/ex_ready   EX handshake
//   id_*                decoded bundle of the OUT entry
// ---------------------------------------------------------------------------
module decode_stage #(
    parameter int XLEN            = 32,
    parameter int REG_AW          = 5,
    // Encoding widths below are fixed by the one-hot layouts above.
    parameter int ALU_OP_WIDTH    = 10,
    parameter int BRANCH_OP_WIDTH = 3,
    parameter int MEM_OP_WIDTH    = 3
) (
    input  logic                       clk,
    input  logic                       rst_b,
    input  logic                       flush,
    input  logic                       if_valid,
    output logic                       if_ready,
    input  logic [31:0]                if_instr,
    input  logic [XLEN-1:0]            if_pc,
    output logic                       id_valid,
    input  logic                       ex_ready,
    output logic [XLEN-1:0]            id_pc,
    output logic [31:0]                id_instr,
    output logic [ALU_OP_WIDTH-1:0]    id_alu_opcode,
    output logic                       id_alu_src1_sel_pc,
    output logic                       id_alu_src2_sel_imm,
    output logic                       id_branch,
    output logic                       id_jump,
    output logic [BRANCH_OP_WIDTH-1:0] id_branch_opcode,
    output logic                       id_mem_read,
    output logic                       id_mem_write,
    output logic [MEM_OP_WIDTH-1:0]    id_mem_opcode,
    output logic                       id_unsign,
    output logic                       id_rd_write,
    output logic [REG_AW-1:0]          id_rd_addr,
    output logic                       id_rs1_read,
    output logic [REG_AW-1:0]          id_rs1_addr,
    output logic                       id_rs2_read,
    output logic [REG_AW-1:0]          id_rs2_addr,
    output logic [XLEN-1:0]            id_immediate,
    output logic                       id_illegal,
    output logic                       id_muldiv,
    output logic [2:0]                 id_muldiv_op
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
`ifdef RV32M_EN
    localparam logic [6:0] F7_MULDIV = 7'b0000001;
`endif

    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD  = ALU_OP_WIDTH'(10'h001);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB  = ALU_OP_WIDTH'(10'h002);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL  = ALU_OP_WIDTH'(10'h004);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLT  = ALU_OP_WIDTH'(10'h008);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU = ALU_OP_WIDTH'(10'h010);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR  = ALU_OP_WIDTH'(10'h020);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL  = ALU_OP_WIDTH'(10'h040);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA  = ALU_OP_WIDTH'(10'h080);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OR   = ALU_OP_WIDTH'(10'h100);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_AND  = ALU_OP_WIDTH'(10'h200);

    typedef struct packed {
        logic [XLEN-1:0]            pc;
        logic [31:0]                instr;
        logic [ALU_OP_WIDTH-1:0]    alu_op;
        logic                       src1_pc;
        logic                       src2_imm;
        logic                       branch;
        logic                       jump;
        logic [BRANCH_OP_WIDTH-1:0] br_op;
        logic                       mem_read;
        logic                       mem_write;
        logic [MEM_OP_WIDTH-1:0]    mem_op;
        logic                       unsign;
        logic                       rd_write;
        logic [REG_AW-1:0]          rd_addr;
        logic                       rs1_read;
        logic [REG_AW-1:0]          rs1_addr;
        logic                       rs2_read;
        logic [REG_AW-1:0]          rs2_addr;
        logic [XLEN-1:0]            imm;
        logic                       illegal;
        logic                       muldiv;
        logic [2:0]                 muldiv_op;
    } entry_t;

    // Shared ALU mapping for OP and OP-IMM; alt selects SUB/SRA.
    function automatic logic [ALU_OP_WIDTH-1:0] alu_base(input logic [2:0] f3,
                                                         input logic alt);
        logic [ALU_OP_WIDTH-1:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = if_instr[6:0];
    assign funct3 = if_instr[14:12];
    assign funct7 = if_instr[31:25];

    assign imm_i = {{20{if_instr[31]}}, if_instr[31:20]};
    assign imm_s = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
    assign imm_b = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                    if_instr[30:25], if_instr[11:8], 1'b0};
    assign imm_u = {if_instr[31:12], 12'b0};
    assign imm_j = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                    if_instr[20], if_instr[30:21], 1'b0};

    // ---- p0: combinational decode of the incoming instruction ----
    entry_t dec_p0;
    logic   illegal_p0;

    always_comb begin
        dec_p0          = '0;
        illegal_p0      = 1'b0;
        dec_p0.pc       = if_pc;
        dec_p0.instr    = if_instr;
        dec_p0.rd_addr  = REG_AW'(if_instr[11:7]);
        dec_p0.rs1_addr = REG_AW'(if_instr[19:15]);
        dec_p0.rs2_addr = REG_AW'(if_instr[24:20]);

        case (opcode)
            OPC_LUI: begin
                dec_p0.alu_op   = ALU_ADD;
                dec_p0.src2_imm = 1'b1;
                dec_p0.rd_write = 1'b1;
                dec_p0.rs1_addr = '0;
                dec_p0.imm      = XLEN'(imm_u);
            end
            OPC_AUIPC: begin
                dec_p0.alu_op   = ALU_ADD;
                dec_p0.src1_pc  = 1'b1;
                dec_p0.src2_imm = 1'b1;
                dec_p0.rd_write = 1'b1;
                dec_p0.imm      = XLEN'(imm_u);
            end
            OPC_JAL: begin
                dec_p0.alu_op   = ALU_ADD;
                dec_p0.src1_pc  = 1'b1;
                dec_p0.src2_imm = 1'b1;
                dec_p0.jump     = 1'b1;
                dec_p0.rd_write = 1'b1;
                dec_p0.imm      = XLEN'(imm_j);
            end
            OPC_JALR: begin
                dec_p0.alu_op   = ALU_ADD;
                dec_p0.src2_imm = 1'b1;
                dec_p0.jump     = 1'b1;
                dec_p0.rd_write = 1'b1;
                dec_p0.rs1_read = 1'b1;
                dec_p0.imm      = XLEN'(imm_i);
                illegal_p0      = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                // EQ family compares via SUB, LT family via SLT/SLTU;
                // funct3[0] inverts the outcome (BNE/BGE/BGEU).
                dec_p0.alu_op   = !funct3[2] ? ALU_SUB :
                                  (funct3[1] ? ALU_SLTU : ALU_SLT);
                dec_p0.br_op    = BRANCH_OP_WIDTH'({funct3[0], funct3[2], ~funct3[2]});
                dec_p0.unsign   = funct3[1];
                dec_p0.src1_pc  = 1'b1;
                dec_p0.branch   = 1'b1;
                dec_p0.rs1_read = 1'b1;
                dec_p0.rs2_read = 1'b1;
                dec_p0.imm      = XLEN'(imm_b);
                illegal_p0      = (funct3[2:1] == 2'b01);
            end
            OPC_LOAD: begin
                dec_p0.alu_op   = ALU_ADD;
                dec_p0.src2_imm = 1'b1;
                dec_p0.mem_read = 1'b1;
                dec_p0.rd_write = 1'b1;
                dec_p0.rs1_read = 1'b1;
                dec_p0.unsign   = funct3[2];
                dec_p0.imm      = XLEN'(imm_i);
                dec_p0.mem_op   = MEM_OP_WIDTH'(3'b001 << funct3[1:0]);
                illegal_p0      = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
            end
            OPC_STORE: begin
                dec_p0.alu_op    = ALU_ADD;
                dec_p0.src2_imm  = 1'b1;
                dec_p0.mem_write = 1'b1;
                dec_p0.rs1_read  = 1'b1;
                dec_p0.rs2_read  = 1'b1;
                dec_p0.imm       = XLEN'(imm_s);
                dec_p0.mem_op    = MEM_OP_WIDTH'(3'b001 << funct3[1:0]);
                illegal_p0       = (funct3 > 3'b010);
            end
            OPC_OPIMM: begin
                // instr[30] only distinguishes SRAI; for other funct3 it is
                // an immediate bit.
                dec_p0.alu_op   = alu_base(funct3, (funct3 == 3'b101) && if_instr[30]);
                dec_p0.src2_imm = 1'b1;
                dec_p0.rd_write = 1'b1;
                dec_p0.rs1_read = 1'b1;
                dec_p0.imm      = XLEN'(imm_i);
                if (funct3 == 3'b001)
                    illegal_p0 = (funct7 != F7_BASE);
                else if (funct3 == 3'b101)
                    illegal_p0 = (funct7 != F7_BASE) && (funct7 != F7_ALT);
            end
            OPC_OP: begin
                dec_p0.rd_write = 1'b1;
                dec_p0.rs1_read = 1'b1;
                dec_p0.rs2_read = 1'b1;
                if (funct7 == F7_BASE)
                    dec_p0.alu_op = alu_base(funct3, 1'b0);
                else if ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)))
                    dec_p0.alu_op = alu_base(funct3, 1'b1);
`ifdef RV32M_EN
                else if (funct7 == F7_MULDIV) begin
                    dec_p0.muldiv    = 1'b1;
                    dec_p0.muldiv_op = funct3;
                end
`endif
                else
                    illegal_p0 = 1'b1;
            end
            default: illegal_p0 = 1'b1;
        endcase

        if (if_instr[1:0] != 2'b11)
            illegal_p0 = 1'b1;

        // Illegal entries still reach EX but must have no side effects.
        if (illegal_p0) begin
            dec_p0.imm       = '0;
            dec_p0.rd_write  = 1'b0;
            dec_p0.mem_read  = 1'b0;
            dec_p0.mem_write = 1'b0;
            dec_p0.branch    = 1'b0;
            dec_p0.jump      = 1'b0;
            dec_p0.muldiv    = 1'b0;
        end
        dec_p0.illegal = illegal_p0;
    end

    // ---- p1: OUT / SKID entries ----
    entry_t out_p1, skid_p1;
    logic   out_vld_p1, skid_vld_p1, rdy_p1;
    logic   accept, out_free;
    logic   out_vld_n, skid_vld_n, out_ld_in, out_ld_skid, skid_ld_in;

    assign accept   = if_valid && rdy_p1;
    assign out_free = !out_vld_p1 || ex_ready;

    always_comb begin
        out_vld_n   = out_vld_p1;
        skid_vld_n  = skid_vld_p1;
        out_ld_in   = 1'b0;
        out_ld_skid = 1'b0;
        skid_ld_in  = 1'b0;
        if (out_free) begin
            if (skid_vld_p1) begin
                // SKID is older, so it moves up before the new input.
                out_ld_skid = 1'b1;
                out_vld_n   = 1'b1;
                skid_ld_in  = accept;
                skid_vld_n  = accept;
            end else begin
                out_ld_in = accept;
                out_vld_n = accept;
            end
        end else if (accept) begin
            skid_ld_in = 1'b1;
            skid_vld_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            out_vld_p1  <= 1'b0;
            skid_vld_p1 <= 1'b0;
            rdy_p1      <= 1'b1;
            out_p1      <= '0;
            skid_p1     <= '0;
        end else if (flush) begin
            out_vld_p1  <= 1'b0;
            skid_vld_p1 <= 1'b0;
            rdy_p1      <= 1'b1;
        end else begin
            out_vld_p1  <= out_vld_n;
            skid_vld_p1 <= skid_vld_n;
            rdy_p1      <= !skid_vld_n;
            if (out_ld_skid)
                out_p1 <= skid_p1;
            else if (out_ld_in)
                out_p1 <= dec_p0;
            if (skid_ld_in)
                skid_p1 <= dec_p0;
        end
    end

    assign if_ready            = rdy_p1;
    assign id_valid            = out_vld_p1;
    assign id_pc               = out_p1.pc;
    assign id_instr            = out_p1.instr;
    assign id_alu_opcode       = out_p1.alu_op;
    assign id_alu_src1_sel_pc  = out_p1.src1_pc;
    assign id_alu_src2_sel_imm = out_p1.src2_imm;
    assign id_branch           = out_p1.branch;
    assign id_jump             = out_p1.jump;
    assign id_branch_opcode    = out_p1.br_op;
    assign id_mem_read         = out_p1.mem_read;
    assign id_mem_write        = out_p1.mem_write;
    assign id_mem_opcode       = out_p1.mem_op;
    assign id_unsign           = out_p1.unsign;
    assign id_rd_write         = out_p1.rd_write;
    assign id_rd_addr          = out_p1.rd_addr;
    assign id_rs1_read         = out_p1.rs1_read;
    assign id_rs1_addr         = out_p1.rs1_addr;
    assign id_rs2_read         = out_p1.rs2_read;
    assign id_rs2_addr         = out_p1.rs2_addr;
    assign id_immediate        = out_p1.imm;
    assign id_illegal          = out_p1.illegal;
    assign id_muldiv           = out_p1.muldiv;
    assign id_muldiv_op        = out_p1.muldiv_op;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

    localparam logic [9:0] A_ADD  = 10'h001;
    localparam logic [9:0] A_SUB  = 10'h002;
    localparam logic [9:0] A_SLT  = 10'h008;
    localparam logic [9:0] A_SLTU = 10'h010;
    localparam logic [9:0] A_SRA  = 10'h080;
    localparam int NV = 18;

    logic        clk = 1'b0;
    logic        rst_b, flush, if_valid, ex_ready;
    logic        if_ready;
    logic [31:0] if_instr, if_pc;
    logic        id_valid;
    logic [31:0] id_pc, id_instr, id_immediate;
    logic [9:0]  id_alu_opcode;
    logic        id_alu_src1_sel_pc, id_alu_src2_sel_imm, id_branch, id_jump;
    logic [2:0]  id_branch_opcode, id_mem_opcode, id_muldiv_op;
    logic        id_mem_read, id_mem_write, id_unsign, id_rd_write;
    logic        id_rs1_read, id_rs2_read, id_illegal, id_muldiv;
    logic [4:0]  id_rd_addr, id_rs1_addr, id_rs2_addr;

    decode_stage dut (
        .clk(clk), .rst_b(rst_b), .flush(flush),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .id_valid(id_valid), .ex_ready(ex_ready), .id_pc(id_pc), .id_instr(id_instr),
        .id_alu_opcode(id_alu_opcode), .id_alu_src1_sel_pc(id_alu_src1_sel_pc),
        .id_alu_src2_sel_imm(id_alu_src2_sel_imm), .id_branch(id_branch), .id_jump(id_jump),
        .id_branch_opcode(id_branch_opcode), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_opcode(id_mem_opcode), .id_unsign(id_unsign),
        .id_rd_write(id_rd_write), .id_rd_addr(id_rd_addr), .id_rs1_read(id_rs1_read),
        .id_rs1_addr(id_rs1_addr), .id_rs2_read(id_rs2_read), .id_rs2_addr(id_rs2_addr),
        .id_immediate(id_immediate), .id_illegal(id_illegal), .id_muldiv(id_muldiv),
        .id_muldiv_op(id_muldiv_op)
    );

    always #5 clk = ~clk;

    // fl bits: {src1pc, src2imm, branch, jump, mem_rd, mem_wr, unsign, rd_wr,
    //           rs1_rd, rs2_rd, illegal, muldiv}
    typedef struct packed {
        logic [31:0] instr;
        logic [9:0]  alu;
        logic [2:0]  br;
        logic [11:0] fl;
        logic [2:0]  mop;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [31:0] imm;
        logic [2:0]  mdop;
    } vec_t;

    typedef struct packed {
        vec_t        v;
        logic [31:0] pc;
    } exp_t;

    vec_t vec [NV];
    exp_t sb [$];
    exp_t cur_exp;
    int   errors = 0;
    int   checks = 0;
    int   pops   = 0;

    function automatic vec_t mk(logic [31:0] instr, logic [9:0] alu, logic [2:0] br,
                                logic [11:0] fl, logic [2:0] mop, logic [4:0] rd,
                                logic [4:0] rs1, logic [31:0] imm, logic [2:0] mdop);
        vec_t r;
        r.instr = instr; r.alu = alu; r.br = br; r.fl = fl; r.mop = mop;
        r.rd = rd; r.rs1 = rs1; r.imm = imm; r.mdop = mdop;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i);
        if_valid = 1'b1;
        if_instr = vec[i].instr;
        if_pc    = 32'h1000 + 32'(4 * i);
        cur_exp.v  = vec[i];
        cur_exp.pc = if_pc;
    endtask

    // Scoreboard: push on an accepted input, pop on an EX handshake.
    initial begin
        exp_t        e;
        logic [11:0] afl, mask;
        forever begin
            @(negedge clk);
            if (!rst_b || flush) begin
                sb.delete();
            end else begin
                if (id_valid && ex_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_output", {224'b0, id_instr}, 256'hdead);
                    end else begin
                        e = sb.pop_front();
                        pops++;
                        afl = {id_alu_src1_sel_pc, id_alu_src2_sel_imm, id_branch, id_jump,
                               id_mem_read, id_mem_write, id_unsign, id_rd_write,
                               id_rs1_read, id_rs2_read, id_illegal, id_muldiv};
                        mask = e.v.fl[1] ? 12'b0011_1101_0011 : 12'hFFF;
                        chk("order", {id_instr, id_pc}, {e.v.instr, e.pc});
                        if (e.v.fl[1])
                            chk("ctrl_illegal", {244'b0, afl & mask}, {244'b0, e.v.fl & mask});
                        else
                            chk("ctrl", {id_alu_opcode, id_branch_opcode, id_mem_opcode, afl, id_muldiv_op},
                                {e.v.alu, e.v.br, e.v.mop, e.v.fl, e.v.mdop});
                        chk("regs", {id_rd_addr, id_rs1_addr, id_rs2_addr},
                            {e.v.rd, e.v.rs1, e.v.instr[24:20]});
                        chk("imm", {224'b0, id_immediate}, {224'b0, e.v.imm});
                    end
                end
                if (if_valid && if_ready)
                    sb.push_back(cur_exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk_idle(input string nm);
        chk(nm, {id_valid, id_pc, id_instr, id_alu_opcode, id_alu_src1_sel_pc,
                 id_alu_src2_sel_imm, id_branch, id_jump, id_branch_opcode, id_mem_read,
                 id_mem_write, id_mem_opcode, id_unsign, id_rd_write, id_rd_addr,
                 id_rs1_read, id_rs1_addr, id_rs2_read, id_rs2_addr, id_immediate,
                 id_illegal, id_muldiv, id_muldiv_op, ~if_ready}, 256'b0);
    endtask

    initial begin
        int pops0;
        rst_b = 1'b0; flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b0;
        if_instr = '0; if_pc = '0; cur_exp = '0;

        vec[0]  = mk(32'h00500093, A_ADD,  3'b000, 12'b0100_0001_1000, 3'b000, 5'd1,  5'd0,  32'd5,        3'd0);
        vec[1]  = mk(32'hFE209EE3, A_SUB,  3'b101, 12'b1010_0000_1100, 3'b000, 5'd29, 5'd1,  32'hFFFFFFFC, 3'd0);
        vec[2]  = mk(32'h123452B7, A_ADD,  3'b000, 12'b0100_0001_0000, 3'b000, 5'd5,  5'd0,  32'h12345000, 3'd0);
        vec[3]  = mk(32'h80000317, A_ADD,  3'b000, 12'b1100_0001_0000, 3'b000, 5'd6,  5'd0,  32'h80000000, 3'd0);
        vec[4]  = mk(32'hFF9FF0EF, A_ADD,  3'b000, 12'b1101_0001_0000, 3'b000, 5'd1,  5'd31, 32'hFFFFFFF8, 3'd0);
        vec[5]  = mk(32'h00008067, A_ADD,  3'b000, 12'b0101_0001_1000, 3'b000, 5'd0,  5'd1,  32'd0,        3'd0);
        vec[6]  = mk(32'hFFF14383, A_ADD,  3'b000, 12'b0100_1011_1000, 3'b001, 5'd7,  5'd2,  32'hFFFFFFFF, 3'd0);
        vec[7]  = mk(32'h00322423, A_ADD,  3'b000, 12'b0100_0100_1100, 3'b100, 5'd8,  5'd4,  32'd8,        3'd0);
        vec[8]  = mk(32'h4034D413, A_SRA,  3'b000, 12'b0100_0001_1000, 3'b000, 5'd8,  5'd9,  32'h00000403, 3'd0);
        vec[9]  = mk(32'h40C58533, A_SUB,  3'b000, 12'b0000_0001_1100, 3'b000, 5'd10, 5'd11, 32'd0,        3'd0);
        vec[10] = mk(32'h00F736B3, A_SLTU, 3'b000, 12'b0000_0001_1100, 3'b000, 5'd13, 5'd14, 32'd0,        3'd0);
        vec[11] = mk(32'h0020F863, A_SLTU, 3'b110, 12'b1010_0010_1100, 3'b000, 5'd16, 5'd1,  32'd16,       3'd0);
        vec[12] = mk(32'hFFFFFFFF, 10'h0,  3'b000, 12'b0000_0000_0010, 3'b000, 5'd31, 5'd31, 32'd0,        3'd0);
        vec[13] = mk(32'h40001033, 10'h0,  3'b000, 12'b0000_0000_0010, 3'b000, 5'd0,  5'd0,  32'd0,        3'd0);
`ifdef RV32M_EN
        vec[14] = mk(32'h022081B3, 10'h0,  3'b000, 12'b0000_0001_1101, 3'b000, 5'd3,  5'd1,  32'd0,        3'd0);
`else
        vec[14] = mk(32'h022081B3, 10'h0,  3'b000, 12'b0000_0000_0010, 3'b000, 5'd3,  5'd1,  32'd0,        3'd0);
`endif
        vec[15] = mk(32'h0000B003, 10'h0,  3'b000, 12'b0000_0000_0010, 3'b000, 5'd0,  5'd1,  32'd0,        3'd0);
        vec[16] = mk(32'h02009093, 10'h0,  3'b000, 12'b0000_0000_0010, 3'b000, 5'd1,  5'd1,  32'd0,        3'd0);
        vec[17] = mk(32'h00500090, 10'h0,  3'b000, 12'b0000_0000_0010, 3'b000, 5'd1,  5'd0,  32'd0,        3'd0);
        // SLT sanity entry reuses BLT-style mapping via table above; A_SLT kept for readability
        if (A_SLT == 10'h0) $display("unreachable");

        tick(); tick();
        chk_idle("reset_state");
        rst_b = 1'b1;
        tick();
        chk_idle("idle_after_reset");

        // Full-throughput stream through the decode table.
        ex_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            drive(i);
            tick();
            chk("stream_if_ready", {255'b0, if_ready}, 256'd1);
            if (i == 0)
                chk("latency", {id_valid, id_instr}, {1'b1, vec[0].instr});
        end
        if_valid = 1'b0;
        tick(); tick();
        chk("stream_pops", 256'(pops), 256'(NV));
        chk("stream_empty", 256'(sb.size()), 256'd0);

        // Back-pressure: three offered while EX stalls.
        pops0 = pops;
        ex_ready = 1'b0;
        drive(0); tick();
        chk("bp_first", {id_valid, if_ready, id_instr}, {1'b1, 1'b1, vec[0].instr});
        drive(1); tick();
        chk("bp_full", {255'b0, if_ready}, 256'd0);
        drive(2); tick();
        chk("bp_hold", {if_ready, id_instr, id_immediate}, {1'b0, vec[0].instr, vec[0].imm});
        tick();
        chk("bp_hold2", {id_valid, if_ready, id_instr}, {1'b1, 1'b0, vec[0].instr});
        ex_ready = 1'b1;
        tick();
        chk("bp_skid_to_out", {if_ready, id_instr}, {1'b1, vec[1].instr});
        tick();
        chk("bp_third", {id_valid, id_instr}, {1'b1, vec[2].instr});
        if_valid = 1'b0;
        tick();
        chk("bp_drained", {id_valid, if_ready}, {1'b0, 1'b1});
        chk("bp_count", 256'(pops - pops0), 256'd3);

        // Flush with both entries full and a new input offered.
        ex_ready = 1'b0;
        drive(5); tick();
        drive(6); tick();
        chk("flush_full", {255'b0, if_ready}, 256'd0);
        drive(7); flush = 1'b1;
        tick();
        flush = 1'b0; if_valid = 1'b0;
        chk("flush_full_after", {id_valid, if_ready}, {1'b0, 1'b1});
        ex_ready = 1'b1;
        tick(); tick();
        chk("flush_full_quiet", {255'b0, id_valid}, 256'd0);

        // Flush while an input really handshakes: it must be dropped.
        ex_ready = 1'b0;
        drive(3); tick();
        drive(4); flush = 1'b1;
        tick();
        flush = 1'b0; if_valid = 1'b0;
        chk("flush_accept_drop", {id_valid, if_ready}, {1'b0, 1'b1});
        ex_ready = 1'b1;
        tick(); tick();
        chk("flush_accept_quiet", {255'b0, id_valid}, 256'd0);

        // Reset mid-stream discards held entries.
        ex_ready = 1'b0;
        drive(8); tick();
        drive(9); tick();
        if_valid = 1'b0; rst_b = 1'b0;
        tick();
        rst_b = 1'b1;
        chk_idle("midstream_reset");
        ex_ready = 1'b1;
        tick();
        chk("midstream_quiet", {255'b0, id_valid}, 256'd0);

        // Recovery after reset.
        pops0 = pops;
        drive(10); tick();
        if_valid = 1'b0;
        tick(); tick();
        chk("recover_count", 256'(pops - pops0), 256'd1);
        chk("final_empty", 256'(sb.size()), 256'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
